// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared state, parity and width constants for the UART blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_EVEN  = 2'b01;
    localparam logic [1:0] PAR_ODD   = 2'b10;

    localparam int unsigned MIN_WIDTH = 5;

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Clocks-per-bit divisor counter; tick on the last clock of a bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    localparam logic [DIV_WIDTH-1:0] c_ONE = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] r_cnt;

    // tick must not depend on clear: clear is derived from the FSM next state, which uses tick
    assign tick = enable && (r_cnt == (div - c_ONE));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= tick ? '0 : (r_cnt + c_ONE);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame
// Description : UART transmitter with per-frame width/parity/stop/divisor and
//               valid/ready payload input supporting zero-gap streaming.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
    parameter int MAX_DATA_WIDTH = 8,
    parameter int DIV_WIDTH      = 16,
    parameter int RST_DIV        = 1085
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [MAX_DATA_WIDTH-1:0] s_data,
    input  logic [3:0]                cfg_width,
    input  logic [1:0]                cfg_parity,
    input  logic                      cfg_stop2,
    input  logic [DIV_WIDTH-1:0]      cfg_div,
    output logic                      tx,
    output logic                      tx_busy,
    output logic                      tx_done
);
    import uart_pkg::*;

    localparam logic [3:0]           c_MIN_W   = 4'(MIN_WIDTH);
    localparam logic [3:0]           c_MAX_W   = 4'(MAX_DATA_WIDTH);
    localparam logic [DIV_WIDTH-1:0] c_TWO     = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] c_RST_DIV = DIV_WIDTH'(RST_DIV);

    logic [2:0]                r_state;
    logic [MAX_DATA_WIDTH-1:0] r_shift;
    logic [3:0]                r_bit_cnt;
    logic [3:0]                r_width_m1;
    logic                      r_parity_en;
    logic                      r_parity_bit;
    logic                      r_stop2;
    logic [DIV_WIDTH-1:0]      r_div;
    logic                      r_tx;
    logic                      r_done;

    logic [2:0]                w_state_next;
    logic [MAX_DATA_WIDTH-1:0] w_shift_next;
    logic [3:0]                w_cnt_next;
    logic                      w_done_next;
    logic                      w_tx_next;
    logic                      w_tick;
    logic                      w_stop_last;
    logic                      w_accept;
    logic [3:0]                w_width_eff;
    logic [MAX_DATA_WIDTH-1:0] w_masked;
    logic                      w_par_xor;

    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (w_state_next != r_state),
        .enable (r_state != ST_IDLE),
        .div    (r_div),
        .tick   (w_tick)
    );

    assign w_stop_last = (r_bit_cnt == {3'b000, r_stop2});
    assign s_ready     = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_stop_last && w_tick);
    assign w_accept    = s_valid && s_ready;
    assign w_width_eff = ((cfg_width < c_MIN_W) || (cfg_width > c_MAX_W)) ? c_MAX_W : cfg_width;

    // Parity is computed at accept over the effective width only
    always_comb begin
        w_masked = '0;
        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            w_masked[i] = (4'(i) < w_width_eff) ? s_data[i] : 1'b0;
        end
        w_par_xor = ^w_masked;
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_cnt_next   = r_bit_cnt;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (s_valid) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next = ST_DATA;
                    w_cnt_next   = '0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_next = {1'b0, r_shift[MAX_DATA_WIDTH-1:1]};
                    if (r_bit_cnt == r_width_m1) begin
                        w_state_next = r_parity_en ? ST_PARITY : ST_STOP;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next   = r_bit_cnt + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_next = ST_STOP;
                    w_cnt_next   = '0;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (w_stop_last) begin
                        w_done_next  = 1'b1;
                        w_cnt_next   = '0;
                        w_state_next = s_valid ? ST_START : ST_IDLE;
                    end else begin
                        w_cnt_next   = r_bit_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Line level is registered from the next state so the start bit begins the cycle after accept
    always_comb begin
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
            ST_PARITY: w_tx_next = r_parity_bit;
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_width_m1   <= '0;
            r_parity_en  <= 1'b0;
            r_parity_bit <= 1'b0;
            r_stop2      <= 1'b0;
            r_div        <= '0;
            r_tx         <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_cnt_next;
            r_tx      <= w_tx_next;
            r_done    <= w_done_next;
            if (w_accept) begin
                r_shift      <= s_data;
                r_width_m1   <= w_width_eff - 4'd1;
                r_parity_en  <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
                r_parity_bit <= (cfg_parity == PAR_ODD) ? ~w_par_xor : w_par_xor;
                r_stop2      <= cfg_stop2;
                r_div        <= (cfg_div < c_TWO) ? c_RST_DIV : cfg_div;
            end else begin
                r_shift      <= w_shift_next;
            end
        end
    end

    assign tx      = r_tx;
    assign tx_busy = (r_state != ST_IDLE);
    assign tx_done = r_done;

endmodule
`default_nettype wire
